// File: rtl/dual_issue_ctrl_pkg.sv
// Shared pipeline types for the dual-issue controller and its scoreboard.
// Slot 1 logic is built only when DUAL_ISSUE_EN is defined.
package dual_issue_ctrl_pkg;

    localparam int SB_REGS = 32;

    typedef logic [1:0] sb_cnt_t;

    typedef struct packed {
        logic [1:0][4:0] r_reg;
        logic [4:0]      w_reg;
    } register_info_t;

    typedef struct packed {
        logic [31:0]    pc;
        logic           fetch_excp;
        register_info_t register_info;
    } inst_t;

endpackage

// File: rtl/dual_issue_ctrl_scoreboard.sv
// Per-register pending-writer counters with busy/full lookups.
// Lane 1 increment and lookups exist only with DUAL_ISSUE_EN defined.
module issue_scoreboard
    import dual_issue_ctrl_pkg::*;
#(
    parameter int SB_CNT_W = $bits(sb_cnt_t)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic [3:0][4:0] i_rd_reg,
    input  logic [1:0][4:0] i_wr_reg,
    input  logic [1:0]      i_inc,
    input  logic [1:0]      i_wb_valid,
    input  logic [1:0][4:0] i_wb_reg,
    output logic [3:0]      o_rd_busy,
    output logic [1:0]      o_wr_full,
    output logic            o_wr1_almost
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_W-1:0] CNT_ALM = CNT_MAX - 1'b1;

    logic [SB_CNT_W-1:0] r_cnt [SB_REGS];
    logic [SB_CNT_W-1:0] w_nxt [SB_REGS];
    logic [SB_REGS-1:0]  w_uflow;
    logic [1:0]          w_inc;
    logic [1:0]          w_up;
    logic [1:0]          w_dn;
    logic [SB_CNT_W+1:0] w_sum;

`ifdef DUAL_ISSUE_EN
    assign w_inc = i_inc;
`else
    logic w_unused_s1;
    assign w_inc = {1'b0, i_inc[0]};
    assign w_unused_s1 = ^{i_rd_reg[3:2], i_wr_reg[1], i_inc[1]};
`endif

    // Busy/full lookups; r0 is never written so it always reads idle.
    always_comb begin
        o_rd_busy    = '0;
        o_wr_full    = '0;
        o_wr1_almost = 1'b0;
        o_rd_busy[0] = |r_cnt[i_rd_reg[0]];
        o_rd_busy[1] = |r_cnt[i_rd_reg[1]];
        o_wr_full[0] = r_cnt[i_wr_reg[0]] == CNT_MAX;
`ifdef DUAL_ISSUE_EN
        o_rd_busy[2] = |r_cnt[i_rd_reg[2]];
        o_rd_busy[3] = |r_cnt[i_rd_reg[3]];
        o_wr_full[1] = r_cnt[i_wr_reg[1]] == CNT_MAX;
        o_wr1_almost = r_cnt[i_wr_reg[1]] == CNT_ALM;
`endif
    end

    // Merge issue increments and writeback decrements per register.
    always_comb begin
        w_up  = '0;
        w_dn  = '0;
        w_sum = '0;
        for (int i = 0; i < SB_REGS; i++) begin
            w_up = 2'(w_inc[0] && (i_wr_reg[0] == 5'(i)))
                 + 2'(w_inc[1] && (i_wr_reg[1] == 5'(i)));
            w_dn = 2'(i_wb_valid[0] && (i_wb_reg[0] == 5'(i)))
                 + 2'(i_wb_valid[1] && (i_wb_reg[1] == 5'(i)));
            w_sum = {2'b00, r_cnt[i]} + (SB_CNT_W+2)'(w_up);
            w_uflow[i] = (i != 0) && (w_sum < (SB_CNT_W+2)'(w_dn));
            if (i == 0 || w_uflow[i])
                w_nxt[i] = '0;
            else
                w_nxt[i] = SB_CNT_W'(w_sum - (SB_CNT_W+2)'(w_dn));
        end
    end

    // Counter array; reset and flush clear everything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SB_REGS; i++) begin
            if (rst || i_flush)
                r_cnt[i] <= '0;
            else
                r_cnt[i] <= w_nxt[i];
        end
    end

    // Writeback of a register with no pending writer is a protocol error.
    always @(posedge clk) begin
        if (!rst && !i_flush)
            assert (w_uflow == '0)
            else $error("scoreboard: writeback to idle register");
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue decision plus issued-pair pipeline register.
// Define DUAL_ISSUE_EN to enable slot 1; otherwise single issue.
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int SB_CNT_W = $bits(sb_cnt_t)
) (
    input  logic            clk,
    input  logic            rst,
    input  inst_t [1:0]     inst_i,
    input  logic [1:0]      inst_valid_i,
    output logic [1:0]      issue_num_o,
    output logic            backend_stall_o,
    input  logic            exe_stall_i,
    input  logic            flush_i,
    input  logic [1:0]      wb_valid_i,
    input  logic [1:0][4:0] wb_reg_i,
    output inst_t [1:0]     issued_inst_o,
    output logic [1:0]      issued_valid_o
);

    logic [3:0][4:0] w_rd_reg;
    logic [1:0][4:0] w_wr_reg;
    logic [3:0]      w_rd_busy;
    logic [1:0]      w_wr_full;
    logic            w_wr1_almost;
    logic [1:0]      w_inc;
    logic            w_go;
    logic            w_issue0;
    logic            w_issue1;
    inst_t [1:0]     r_inst;
    logic [1:0]      r_valid;

    assign w_rd_reg[0] = inst_i[0].register_info.r_reg[0];
    assign w_rd_reg[1] = inst_i[0].register_info.r_reg[1];
    assign w_rd_reg[2] = inst_i[1].register_info.r_reg[0];
    assign w_rd_reg[3] = inst_i[1].register_info.r_reg[1];
    assign w_wr_reg[0] = inst_i[0].register_info.w_reg;
    assign w_wr_reg[1] = inst_i[1].register_info.w_reg;

    assign w_go = !exe_stall_i && !flush_i && !rst;

    assign w_issue0 = inst_valid_i[0] && !w_rd_busy[0]
                   && !w_rd_busy[1] && !w_wr_full[0] && w_go;

`ifdef DUAL_ISSUE_EN
    logic w_raw;
    logic w_same_w;
    logic w_full1;
    assign w_raw = (w_wr_reg[0] != 5'd0)
                && ((w_rd_reg[2] == w_wr_reg[0])
                 || (w_rd_reg[3] == w_wr_reg[0]));
    assign w_same_w = (w_wr_reg[0] != 5'd0)
                   && (w_wr_reg[0] == w_wr_reg[1]);
    assign w_full1 = w_wr_full[1] || (w_same_w && w_wr1_almost);
    assign w_issue1 = w_issue0 && inst_valid_i[1]
                   && !w_rd_busy[2] && !w_rd_busy[3]
                   && !w_raw && !w_full1
                   && !inst_i[0].fetch_excp
                   && !inst_i[1].fetch_excp;
`else
    logic w_unused_s1;
    assign w_issue1 = 1'b0;
    assign w_unused_s1 = ^{w_rd_busy[3:2], w_wr_full[1], w_wr1_almost};
`endif

    assign w_inc = {w_issue1, w_issue0};
    assign issue_num_o = w_issue1 ? 2'd2 : (w_issue0 ? 2'd1 : 2'd0);
    assign backend_stall_o = exe_stall_i | flush_i;

    issue_scoreboard #(
        .SB_CNT_W (SB_CNT_W)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush_i),
        .i_rd_reg     (w_rd_reg),
        .i_wr_reg     (w_wr_reg),
        .i_inc        (w_inc),
        .i_wb_valid   (wb_valid_i),
        .i_wb_reg     (wb_reg_i),
        .o_rd_busy    (w_rd_busy),
        .o_wr_full    (w_wr_full),
        .o_wr1_almost (w_wr1_almost)
    );

    // Issued pair register; holds under execute stall, bubbles on hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst  <= '0;
            r_valid <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
        end else if (!exe_stall_i) begin
            r_inst  <= inst_i;
            r_valid <= {w_issue1, w_issue0};
        end
    end

    assign issued_inst_o  = r_inst;
    assign issued_valid_o = r_valid;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl; expectations follow DUAL_ISSUE_EN.
// Each task drives one scenario and checks its own results.
module tb_dual_issue_ctrl;
    import dual_issue_ctrl_pkg::*;

`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic            clk;
    logic            rst;
    inst_t [1:0]     inst_i;
    logic [1:0]      inst_valid_i;
    logic [1:0]      issue_num_o;
    logic            backend_stall_o;
    logic            exe_stall_i;
    logic            flush_i;
    logic [1:0]      wb_valid_i;
    logic [1:0][4:0] wb_reg_i;
    inst_t [1:0]     issued_inst_o;
    logic [1:0]      issued_valid_o;

    int n_pass = 0;
    int n_total = 0;

    dual_issue_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .inst_i          (inst_i),
        .inst_valid_i    (inst_valid_i),
        .issue_num_o     (issue_num_o),
        .backend_stall_o (backend_stall_o),
        .exe_stall_i     (exe_stall_i),
        .flush_i         (flush_i),
        .wb_valid_i      (wb_valid_i),
        .wb_reg_i        (wb_reg_i),
        .issued_inst_o   (issued_inst_o),
        .issued_valid_o  (issued_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic inst_t mk(input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] w, input logic e);
        inst_t t;
        t = '0;
        t.register_info.r_reg[0] = a;
        t.register_info.r_reg[1] = b;
        t.register_info.w_reg = w;
        t.fetch_excp = e;
        t.pc = 32'h1000 + {22'd0, a, w};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_valid_i = '0;
        exe_stall_i = 1'b0;
        flush_i = 1'b0;
        wb_valid_i = '0;
        wb_reg_i = '0;
    endtask

    task automatic put(input inst_t a, input inst_t b, input logic [1:0] v);
        inst_i[0] = a;
        inst_i[1] = b;
        inst_valid_i = v;
        #1;
    endtask

    task automatic do_flush();
        idle();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        inst_i = '0;
        repeat (3) tick();
        n_total++;
        if (issued_valid_o !== 2'b00)
            $display("FAIL rst_valid: got %b want 00", issued_valid_o);
        else n_pass++;
        n_total++;
        if (issued_inst_o !== '0)
            $display("FAIL rst_inst: got %h want 0", issued_inst_o);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL rst_num: got %0d want 0", issue_num_o);
        else n_pass++;
        n_total++;
        if (backend_stall_o !== 1'b0)
            $display("FAIL rst_stall: got %b want 0", backend_stall_o);
        else n_pass++;
    endtask

    task automatic test_indep();
        inst_t i0, i1;
        i0 = mk(5'd1, 5'd2, 5'd4, 1'b0);
        i1 = mk(5'd3, 5'd6, 5'd5, 1'b0);
        put(i0, i1, 2'b11);
        n_total++;
        if (issue_num_o !== (DUAL ? 2'd2 : 2'd1))
            $display("FAIL indep_num: got %0d want %0d",
                     issue_num_o, DUAL ? 2 : 1);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (issued_valid_o !== (DUAL ? 2'b11 : 2'b01))
            $display("FAIL indep_valid: got %b", issued_valid_o);
        else n_pass++;
        n_total++;
        if (issued_inst_o[0] !== i0)
            $display("FAIL indep_inst0: got %h want %h",
                     issued_inst_o[0], i0);
        else n_pass++;
        put(mk(5'd4, 5'd0, 5'd0, 1'b0), '0, 2'b01);
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL indep_r4_busy: got %0d want 0", issue_num_o);
        else n_pass++;
        put(mk(5'd5, 5'd0, 5'd0, 1'b0), '0, 2'b01);
        n_total++;
        if (issue_num_o !== (DUAL ? 2'd0 : 2'd1))
            $display("FAIL indep_r5_state: got %0d want %0d",
                     issue_num_o, DUAL ? 0 : 1);
        else n_pass++;
        inst_valid_i = '0;
        wb_reg_i[0] = 5'd4;
        wb_reg_i[1] = 5'd5;
        wb_valid_i = {DUAL, 1'b1};
        tick();
        idle();
        put(mk(5'd4, 5'd5, 5'd0, 1'b0), '0, 2'b01);
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL indep_freed: got %0d want 1", issue_num_o);
        else n_pass++;
        do_flush();
    endtask

    task automatic test_raw();
        inst_t i0, i1;
        i0 = mk(5'd1, 5'd2, 5'd4, 1'b0);
        i1 = mk(5'd4, 5'd3, 5'd8, 1'b0);
        put(i0, i1, 2'b11);
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL raw_num: got %0d want 1", issue_num_o);
        else n_pass++;
        tick();
        n_total++;
        if (issued_valid_o !== 2'b01)
            $display("FAIL raw_valid: got %b want 01", issued_valid_o);
        else n_pass++;
        put(i1, '0, 2'b01);
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL raw_wait: got %0d want 0", issue_num_o);
        else n_pass++;
        tick();
        n_total++;
        if (issued_valid_o !== 2'b00)
            $display("FAIL raw_bubble: got %b want 00", issued_valid_o);
        else n_pass++;
        wb_reg_i[0] = 5'd4;
        wb_valid_i = 2'b01;
        #1;
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL raw_nobypass: got %0d want 0", issue_num_o);
        else n_pass++;
        tick();
        wb_valid_i = '0;
        #1;
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL raw_issue: got %0d want 1", issue_num_o);
        else n_pass++;
        tick();
        n_total++;
        if (issued_valid_o !== 2'b01 || issued_inst_o[0] !== i1)
            $display("FAIL raw_issued: got %b/%h want 01/%h",
                     issued_valid_o, issued_inst_o[0], i1);
        else n_pass++;
        do_flush();
    endtask

    task automatic test_full();
        inst_t w7;
        w7 = mk(5'd0, 5'd0, 5'd7, 1'b0);
        put(w7, '0, 2'b01);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (issue_num_o !== 2'd1)
                $display("FAIL full_fill%0d: got %0d want 1",
                         k, issue_num_o);
            else n_pass++;
            tick();
        end
        put(w7, w7, 2'b11);
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL full_same_w: got %0d want 1", issue_num_o);
        else n_pass++;
        tick();
        put(w7, '0, 2'b01);
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL full_r7: got %0d want 0", issue_num_o);
        else n_pass++;
        wb_reg_i[0] = 5'd7;
        wb_valid_i = 2'b01;
        #1;
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL full_wb_cycle: got %0d want 0", issue_num_o);
        else n_pass++;
        tick();
        wb_valid_i = '0;
        #1;
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL full_after_wb: got %0d want 1", issue_num_o);
        else n_pass++;
        tick();
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL full_refull: got %0d want 0", issue_num_o);
        else n_pass++;
        do_flush();
    endtask

    task automatic test_stall();
        inst_t a0, a1;
        a0 = mk(5'd1, 5'd2, 5'd12, 1'b0);
        a1 = mk(5'd3, 5'd4, 5'd13, 1'b0);
        put(a0, a1, 2'b11);
        tick();
        exe_stall_i = 1'b1;
        put(mk(5'd5, 5'd6, 5'd10, 1'b0), mk(5'd7, 5'd8, 5'd11, 1'b0), 2'b11);
        n_total++;
        if (backend_stall_o !== 1'b1)
            $display("FAIL stall_out: got %b want 1", backend_stall_o);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (issue_num_o !== 2'd0)
                $display("FAIL stall_num%0d: got %0d want 0",
                         k, issue_num_o);
            else n_pass++;
            tick();
            n_total++;
            if (issued_inst_o[0] !== a0
                || issued_valid_o !== (DUAL ? 2'b11 : 2'b01))
                $display("FAIL stall_hold%0d: got %h/%b want %h",
                         k, issued_inst_o[0], issued_valid_o, a0);
            else n_pass++;
        end
        exe_stall_i = 1'b0;
        put(mk(5'd10, 5'd11, 5'd0, 1'b0), '0, 2'b01);
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL stall_no_inc: got %0d want 1", issue_num_o);
        else n_pass++;
        put(mk(5'd12, 5'd0, 5'd0, 1'b0), '0, 2'b01);
        n_total++;
        if (issue_num_o !== 2'd0)
            $display("FAIL stall_r12: got %0d want 0", issue_num_o);
        else n_pass++;
        do_flush();
    endtask

    task automatic test_flush();
        inst_t dep;
        put(mk(5'd0, 5'd0, 5'd9, 1'b0), '0, 2'b01);
        tick();
        put(mk(5'd0, 5'd0, 5'd3, 1'b0), '0, 2'b01);
        repeat (2) tick();
        dep = mk(5'd3, 5'd9, 5'd0, 1'b0);
        put(dep, '0, 2'b01);
        n_total++;
        if (issue_num_o !== 2'd0 || issued_valid_o !== 2'b01)
            $display("FAIL flush_pre: got %0d/%b want 0/01",
                     issue_num_o, issued_valid_o);
        else n_pass++;
        flush_i = 1'b1;
        wb_reg_i[0] = 5'd5;
        wb_valid_i = 2'b01;
        #1;
        n_total++;
        if (issue_num_o !== 2'd0 || backend_stall_o !== 1'b1)
            $display("FAIL flush_cycle: got %0d/%b want 0/1",
                     issue_num_o, backend_stall_o);
        else n_pass++;
        tick();
        flush_i = 1'b0;
        wb_valid_i = '0;
        #1;
        n_total++;
        if (issued_valid_o !== 2'b00)
            $display("FAIL flush_valid: got %b want 00", issued_valid_o);
        else n_pass++;
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL flush_dep: got %0d want 1", issue_num_o);
        else n_pass++;
        do_flush();
    endtask

    task automatic test_excp();
        put(mk(5'd1, 5'd2, 5'd4, 1'b1), mk(5'd3, 5'd6, 5'd5, 1'b0), 2'b11);
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL excp_slot0: got %0d want 1", issue_num_o);
        else n_pass++;
        put(mk(5'd1, 5'd2, 5'd4, 1'b0), mk(5'd3, 5'd6, 5'd5, 1'b1), 2'b11);
        n_total++;
        if (issue_num_o !== 2'd1)
            $display("FAIL excp_slot1: got %0d want 1", issue_num_o);
        else n_pass++;
        idle();
    endtask

    task automatic test_random();
        inst_t a, b;
        for (int k = 0; k < 1000; k++) begin
            a = mk(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                   5'd0, 1'b0);
            b = mk(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                   5'd0, 1'b0);
            put(a, b, 2'b11);
            n_total++;
            if (issue_num_o !== (DUAL ? 2'd2 : 2'd1))
                $display("FAIL rand_num%0d: got %0d want %0d",
                         k, issue_num_o, DUAL ? 2 : 1);
            else n_pass++;
            tick();
        end
        n_total++;
        if (issued_valid_o !== (DUAL ? 2'b11 : 2'b01))
            $display("FAIL rand_valid: got %b", issued_valid_o);
        else n_pass++;
        idle();
    endtask

    initial begin
        test_reset();
        test_indep();
        test_raw();
        test_full();
        test_stall();
        test_flush();
        test_excp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
